// File: rtl/relay_seq_pkg.sv
// ============================================================================
// Module : relay_seq_pkg
// Brief  : Shared state encoding, default timing and counter sizing for the
//          relay multiplexer sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package relay_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAKE  = 2'd1,
      GRANT = 2'd2,
      BREAK = 2'd3
   } state_t;

   localparam int c_DEF_N          = 4;
   localparam int c_DEF_SETTLE_CYC = 3;
   localparam int c_DEF_BREAK_CYC  = 2;
   localparam int c_DEF_HOLD_MAX   = 0;

   // One width serves settle, break and hold counters alike.
   function automatic int cnt_width(input int s, input int b, input int h);
      int m;
      m = s;
      if (b > m) m = b;
      if (h > m) m = h;
      return $clog2(m + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/relay_mux_sequencer_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from i_ptr and
//          wrapping at N.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import relay_seq_pkg::*;
#(
   parameter int N = c_DEF_N
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic                 o_valid,
   output logic [$clog2(N)-1:0] o_winner
);

   localparam int c_IW = $clog2(N);

   always_comb begin
      int                j;
      logic [c_IW-1:0]   w_idx;
      j        = 0;
      w_idx    = '0;
      o_valid  = |i_req;
      o_winner = '0;
      // Walk from the farthest offset down so the nearest requester wins last.
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(i_ptr) + i;
         if (j >= N) j = j - N;
         w_idx = c_IW'(j);
         if (i_req[w_idx]) o_winner = w_idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/relay_mux_sequencer.sv
// ============================================================================
// Module : relay_mux_sequencer
// Brief  : Break-before-make sequencer sharing one analog node between N
//          relay-switched requesters, granting only after contact settle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module relay_mux_sequencer
   import relay_seq_pkg::*;
#(
   parameter int N          = c_DEF_N,
   parameter int SETTLE_CYC = c_DEF_SETTLE_CYC,
   parameter int BREAK_CYC  = c_DEF_BREAK_CYC,
   parameter int HOLD_MAX   = c_DEF_HOLD_MAX
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         relay_on,
   output logic [N-1:0]         grant,
   output logic                 busy,
   output logic [$clog2(N)-1:0] owner
);

   localparam int c_IW = $clog2(N);
   localparam int c_CW = cnt_width(SETTLE_CYC, BREAK_CYC, HOLD_MAX);

   state_t            r_state, w_state_nxt;
   logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
   logic [c_CW-1:0]   r_hold, w_hold_nxt, w_hold_inc;
   logic [c_IW-1:0]   r_ptr, w_ptr_nxt, w_ptr_adv;
   logic [c_IW-1:0]   r_owner, w_owner_nxt, w_win;
   logic [N-1:0]      r_relay_on, w_relay_on_nxt;
   logic [N-1:0]      r_grant, w_grant_nxt;
   logic [N-1:0]      w_own_oh, w_own_oh_nxt;
   logic              r_busy, w_busy_nxt;
   logic              w_valid, w_own_req, w_others, w_release;

   rr_arbiter #(.N(N)) u_arb (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_valid  (w_valid),
      .o_winner (w_win)
   );

   assign w_own_oh   = {{(N-1){1'b0}}, 1'b1} << r_owner;
   assign w_own_req  = |(req & w_own_oh);
   assign w_others   = |(req & ~w_own_oh);
   assign w_ptr_adv  = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;
   assign w_hold_inc = (&r_hold) ? r_hold : r_hold + 1'b1;
   // Preemption counts the current granted cycle, so HOLD_MAX cycles are served.
   assign w_release  = !w_own_req ||
                       ((HOLD_MAX > 0) && (int'(w_hold_inc) >= HOLD_MAX) && w_others);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_hold     <= '0;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_relay_on <= '0;
         r_grant    <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hold     <= w_hold_nxt;
         r_ptr      <= w_ptr_nxt;
         r_owner    <= w_owner_nxt;
         r_relay_on <= w_relay_on_nxt;
         r_grant    <= w_grant_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hold_nxt  = r_hold;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_state_nxt = MAKE;
               w_owner_nxt = w_win;
               w_cnt_nxt   = c_CW'(SETTLE_CYC - 1);
            end
         end
         MAKE: begin
            if (!w_own_req) begin
               w_state_nxt = BREAK;
               w_cnt_nxt   = c_CW'(BREAK_CYC - 1);
               w_ptr_nxt   = w_ptr_adv;
            end else if (r_cnt == '0) begin
               w_state_nxt = GRANT;
               w_hold_nxt  = '0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         GRANT: begin
            w_hold_nxt = w_hold_inc;
            if (w_release) begin
               w_state_nxt = BREAK;
               w_cnt_nxt   = c_CW'(BREAK_CYC - 1);
               w_ptr_nxt   = w_ptr_adv;
               w_hold_nxt  = '0;
            end
         end
         BREAK: begin
            if (r_cnt == '0) w_state_nxt = IDLE;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from next state and registered so coil drive never glitches.
   always_comb begin
      w_own_oh_nxt   = {{(N-1){1'b0}}, 1'b1} << w_owner_nxt;
      w_relay_on_nxt = '0;
      w_grant_nxt    = '0;
      w_busy_nxt     = (w_state_nxt != IDLE);
      if (w_state_nxt == MAKE || w_state_nxt == GRANT) w_relay_on_nxt = w_own_oh_nxt;
      if (w_state_nxt == GRANT)                         w_grant_nxt    = w_own_oh_nxt;
   end

   assign relay_on = r_relay_on;
   assign grant    = r_grant;
   assign busy     = r_busy;
   assign owner    = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_relay_mux_sequencer.sv
// ============================================================================
// Module : tb_relay_mux_sequencer
// Brief  : Directed self-checking bench for relay_mux_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_relay_mux_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, req_p;
   logic [3:0] relay_on, grant, relay_on_p, grant_p;
   logic       busy, busy_p;
   logic [1:0] owner, owner_p;

   int checks = 0;
   int errors = 0;

   int cyc       = 0;
   int last_fall = -100;
   int min_gap   = 1000;
   int inv_viol  = 0;
   logic [3:0] prev_on = '0, prev_on_p = '0;

   always #5 clk = ~clk;

   relay_mux_sequencer #(.N(4), .SETTLE_CYC(3), .BREAK_CYC(2), .HOLD_MAX(0)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .relay_on(relay_on),
      .grant(grant), .busy(busy), .owner(owner)
   );

   relay_mux_sequencer #(.N(4), .SETTLE_CYC(3), .BREAK_CYC(2), .HOLD_MAX(8)) dut_p (
      .clk(clk), .rst_n(rst_n), .req(req_p), .relay_on(relay_on_p),
      .grant(grant_p), .busy(busy_p), .owner(owner_p)
   );

   // Invariant and dead-time monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!$onehot0(relay_on) || ((grant & ~relay_on) != 4'b0)) inv_viol = inv_viol + 1;
      if (!$onehot0(relay_on_p) || ((grant_p & ~relay_on_p) != 4'b0)) inv_viol = inv_viol + 1;
      if (prev_on != 4'b0 && relay_on != 4'b0 && prev_on != relay_on) inv_viol = inv_viol + 1;
      if (prev_on_p != 4'b0 && relay_on_p != 4'b0 && prev_on_p != relay_on_p) inv_viol = inv_viol + 1;
      if (!rst_n) last_fall = -100;
      else if (prev_on != 4'b0 && relay_on == 4'b0) last_fall = cyc;
      else if (prev_on == 4'b0 && relay_on != 4'b0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
      prev_on   = relay_on;
      prev_on_p = relay_on_p;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      req   = 4'b0;
      req_p = 4'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (relay_on !== 4'b0) begin errors++; $display("FAIL reset_relay_on: got %b want 0000", relay_on); end
      checks++; if (grant !== 4'b0)    begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (owner !== 2'd0)    begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
   endtask

   task automatic test_single();
      req = 4'b0001;
      step(1);
      checks++; if (relay_on !== 4'b0001) begin errors++; $display("FAIL single_make: relay_on=%b want 0001", relay_on); end
      checks++; if (grant !== 4'b0000)    begin errors++; $display("FAIL single_early_grant: grant=%b want 0000", grant); end
      checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL single_busy: busy=%b want 1", busy); end
      step(2);
      checks++; if (grant !== 4'b0000)    begin errors++; $display("FAIL single_settle: grant=%b want 0000 at edge 3", grant); end
      step(1);
      checks++; if (grant !== 4'b0001)    begin errors++; $display("FAIL single_grant: grant=%b want 0001 at edge 4", grant); end
      step(6);
      req = 4'b0000;
      step(1);
      checks++; if (relay_on !== 4'b0 || grant !== 4'b0) begin errors++; $display("FAIL single_release: relay_on=%b grant=%b want 0000 0000", relay_on, grant); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_break_busy: busy=%b want 1", busy); end
      step(1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_break_busy2: busy=%b want 1 at edge 12", busy); end
      step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0 at edge 13", busy); end
   endtask

   task automatic test_contention();
      logic [3:0] exp;
      int         idx, n;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         idx = k % 4;
         exp = 4'b0001 << idx;
         n = 0;
         while (grant === 4'b0 && n < 20) begin step(1); n++; end
         checks++; if (grant !== exp) begin errors++; $display("FAIL contention_order%0d: grant=%b want %b", k, grant, exp); end
         step(4);
         checks++; if (grant !== exp) begin errors++; $display("FAIL contention_hold%0d: grant=%b want %b", k, grant, exp); end
         req[idx] = 1'b0;
         step(1);
         checks++; if (relay_on !== 4'b0 || grant !== 4'b0) begin errors++; $display("FAIL contention_rel%0d: relay_on=%b grant=%b want 0000 0000", k, relay_on, grant); end
         req[idx] = 1'b1;
      end
      req = 4'b0;
      step(6);
      checks++; if (min_gap < 3) begin errors++; $display("FAIL contention_gap: min gap %0d want >= 3", min_gap); end
      checks++; if (inv_viol !== 0) begin errors++; $display("FAIL contention_invariants: %0d violations want 0", inv_viol); end
   endtask

   task automatic test_abort_wrap();
      do_reset();
      req = 4'b0100;
      step(1);
      checks++; if (relay_on !== 4'b0100 || owner !== 2'd2) begin errors++; $display("FAIL abort_make: relay_on=%b owner=%0d want 0100 2", relay_on, owner); end
      step(1);
      checks++; if (grant !== 4'b0) begin errors++; $display("FAIL abort_no_grant: grant=%b want 0000", grant); end
      req = 4'b1001;
      step(1);
      checks++; if (relay_on !== 4'b0 || grant !== 4'b0) begin errors++; $display("FAIL abort_release: relay_on=%b grant=%b want 0000 0000 at edge 3", relay_on, grant); end
      step(3);
      checks++; if (relay_on !== 4'b1000 || owner !== 2'd3) begin errors++; $display("FAIL abort_next: relay_on=%b owner=%0d want 1000 3 at edge 6", relay_on, owner); end
      step(3);
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL abort_next_grant: grant=%b want 1000", grant); end
      step(1);
      req = 4'b0001;
      step(1);
      req = 4'b1001;
      step(3);
      checks++; if (relay_on !== 4'b0001) begin errors++; $display("FAIL wrap_to_0: relay_on=%b want 0001", relay_on); end
      step(3);
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: grant=%b want 0001", grant); end
      req = 4'b1000;
      step(4);
      checks++; if (relay_on !== 4'b1000) begin errors++; $display("FAIL wrap_then_3: relay_on=%b want 1000", relay_on); end
      req = 4'b0;
      step(5);
   endtask

   task automatic test_preempt();
      int n, m;
      do_reset();
      req_p = 4'b0001;
      step(2);
      req_p = 4'b0011;
      n = 0;
      while (grant_p === 4'b0 && n < 20) begin step(1); n++; end
      checks++; if (grant_p !== 4'b0001) begin errors++; $display("FAIL preempt_first: grant=%b want 0001", grant_p); end
      n = 0;
      while (grant_p === 4'b0001 && n < 40) begin n++; step(1); end
      checks++; if (n !== 8) begin errors++; $display("FAIL preempt_hold: held %0d cycles want 8", n); end
      m = 1;
      while (grant_p === 4'b0 && m < 40) begin step(1); m++; end
      checks++; if (m !== 7) begin errors++; $display("FAIL preempt_gap: gap %0d cycles want 7", m); end
      checks++; if (grant_p !== 4'b0010) begin errors++; $display("FAIL preempt_next: grant=%b want 0010", grant_p); end
      n = 0;
      while (grant_p !== 4'b0001 && n < 40) begin step(1); n++; end
      checks++; if (grant_p !== 4'b0001) begin errors++; $display("FAIL preempt_return: grant=%b want 0001", grant_p); end
      req_p = 4'b0;
      step(6);
   endtask

   task automatic test_reset_mid_grant();
      int n;
      do_reset();
      req = 4'b0001;
      n = 0;
      while (grant === 4'b0 && n < 20) begin step(1); n++; end
      req = 4'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin step(1); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy=%b want 0", busy); end
      req = 4'b0100;
      n = 0;
      while (grant === 4'b0 && n < 20) begin step(1); n++; end
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_grant: grant=%b want 0100", grant); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (relay_on !== 4'b0 || grant !== 4'b0) begin errors++; $display("FAIL midrst_outputs: relay_on=%b grant=%b want 0000 0000", relay_on, grant); end
      checks++; if (owner !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_owner: owner=%0d busy=%b want 0 0", owner, busy); end
      req = 4'b0101;
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(1);
      checks++; if (relay_on !== 4'b0001 || owner !== 2'd0) begin errors++; $display("FAIL midrst_ptr: relay_on=%b owner=%0d want 0001 0", relay_on, owner); end
      req = 4'b0;
      step(6);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0;
      req_p = 4'b0;
      #3;
      test_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_single();
      test_contention();
      test_abort_wrap();
      test_preempt();
      test_reset_mid_grant();
      checks++; if (inv_viol !== 0) begin errors++; $display("FAIL final_invariants: %0d violations want 0", inv_viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
